// File: rtl/adc_pkg.sv
// adc_pkg: shared definitions for the serial ADC device emulator.
//   - default channel count, sample width and frame length
//   - SCLK rise numbers on which the controller shifts in the channel address
//   - channel/sample typedefs and the responder state encoding
package adc_pkg;

   localparam int ADC_NCH        = 8;
   localparam int ADC_DW         = 12;
   localparam int ADC_FRAME_BITS = 16;

   // Address bits arrive MSB first on these SCLK rises (1-based count).
   localparam int ADDR_RISE_FIRST = 3;
   localparam int ADDR_RISE_LAST  = 5;
   localparam int ADDR_BITS       = ADDR_RISE_LAST - ADDR_RISE_FIRST + 1;

   typedef logic [2:0]  ch_t;
   typedef logic [11:0] sample_t;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } resp_state_t;

endpackage

// File: rtl/sync_edge.sv
// sync_edge: multi-flop synchronizer with rise/fall pulse detection.
//   pin   : asynchronous input
//   level : synchronized level (last synchronizer stage)
//   rise  : one-cycle pulse when level goes 0->1
//   fall  : one-cycle pulse when level goes 1->0
// RST_VAL presets every stage so an idle line produces no edge out of reset.
module sync_edge #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pin,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   prev_reg;

   genvar gi;
   generate
      for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
         if (gi == 0) begin : g_first
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) sync_reg[gi] <= RST_VAL;
               else        sync_reg[gi] <= pin;
            end
         end else begin : g_rest
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) sync_reg[gi] <= RST_VAL;
               else        sync_reg[gi] <= sync_reg[gi-1];
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prev_reg <= RST_VAL;
      else        prev_reg <= sync_reg[SYNC_STAGES-1];
   end

   assign level = sync_reg[SYNC_STAGES-1];
   assign rise  = level & ~prev_reg;
   assign fall  = ~level & prev_reg;

endmodule

// File: rtl/adc_serial_responder.sv
// adc_serial_responder: device-side emulator of an 8-channel serial ADC.
// Oversamples CS_N/SCLK/SADDR in the CLOCK_50 domain and answers each frame
// with {leading zeros, ch_data[channel]}, where the channel was addressed by
// the controller during the previous frame.
//   CLOCK_50    : system clock (>= 4x SCLK)
//   n_reset     : asynchronous active-low reset
//   ADC_CS_N    : chip select, active low
//   ADC_SCLK    : serial clock, idles high
//   ADC_SADDR   : channel address from the controller
//   ADC_SDAT    : serial data to the controller
//   sdat_oe     : ADC_SDAT output enable, high only inside a frame
//   ch_data     : packed samples, channel k at [k*DW +: DW]
//   cur_ch      : channel being returned in the current frame
//   frame_done  : one-cycle pulse per completed frame
//   frame_abort : one-cycle pulse when CS_N rises mid-frame
//   frame_cnt   : completed-frame counter (wraps)
module adc_serial_responder
   import adc_pkg::*;
#(
   parameter int NCH         = ADC_NCH,
   parameter int DW          = ADC_DW,
   parameter int FRAME_BITS  = ADC_FRAME_BITS,
   parameter int SYNC_STAGES = 2,
   parameter int RST_CH      = 0
) (
   input  logic                     CLOCK_50,
   input  logic                     n_reset,
   input  logic                     ADC_CS_N,
   input  logic                     ADC_SCLK,
   input  logic                     ADC_SADDR,
   output logic                     ADC_SDAT,
   output logic                     sdat_oe,
   input  logic [NCH*DW-1:0]        ch_data,
   output logic [$clog2(NCH)-1:0]   cur_ch,
   output logic                     frame_done,
   output logic                     frame_abort,
   output logic [15:0]              frame_cnt
);

   localparam int CHW = $clog2(NCH);
   localparam int CW  = $clog2(FRAME_BITS + 1);
   localparam logic [CW-1:0] LAST_RISE = CW'(FRAME_BITS);

   // ---------------- pin synchronizers ----------------
   logic cs_lvl, cs_rise, cs_fall;
   logic sclk_lvl, sclk_rise, sclk_fall;
   logic saddr_lvl, saddr_rise, saddr_fall;

   sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
      .clk(CLOCK_50), .rst_n(n_reset), .pin(ADC_CS_N),
      .level(cs_lvl), .rise(cs_rise), .fall(cs_fall));

   sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sclk (
      .clk(CLOCK_50), .rst_n(n_reset), .pin(ADC_SCLK),
      .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));

   sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_saddr (
      .clk(CLOCK_50), .rst_n(n_reset), .pin(ADC_SADDR),
      .level(saddr_lvl), .rise(saddr_rise), .fall(saddr_fall));

   // Only edges of CS_N/SCLK and the level of SADDR drive the logic.
   logic unused_sync;
   assign unused_sync = &{1'b0, cs_lvl, sclk_lvl, saddr_rise, saddr_fall};

   // ---------------- state ----------------
   resp_state_t            state_reg, state_next;
   logic [FRAME_BITS-1:0]  shift_reg, shift_next;
   logic [CW-1:0]          cnt_reg, cnt_next;
   logic [ADDR_BITS-1:0]   addr_reg, addr_next;
   logic [CHW-1:0]         cur_ch_reg, cur_ch_next;
   logic [CHW-1:0]         next_ch_reg, next_ch_next;
   logic                   sdat_reg, sdat_next;
   logic                   oe_reg, oe_next;
   logic                   done_reg, done_next;
   logic                   abort_reg, abort_next;
   logic [15:0]            frame_cnt_reg, frame_cnt_next;

   logic [CW-1:0]          cnt_inc;
   logic [CHW-1:0]         addr_ch;
   logic [FRAME_BITS-1:0]  load_word;
   logic [FRAME_BITS-1:0]  reload_word;

   assign cnt_inc     = cnt_reg + 1'b1;
   assign addr_ch     = CHW'(addr_reg);
   // Zero-extension supplies the FRAME_BITS-DW leading zero bits.
   assign load_word   = FRAME_BITS'(ch_data[int'(next_ch_reg)*DW +: DW]);
   assign reload_word = FRAME_BITS'(ch_data[int'(addr_ch)*DW +: DW]);

   always_ff @(posedge CLOCK_50 or negedge n_reset) begin
      if (!n_reset) begin
         state_reg     <= IDLE;
         shift_reg     <= '0;
         cnt_reg       <= '0;
         addr_reg      <= '0;
         cur_ch_reg    <= CHW'(RST_CH);
         next_ch_reg   <= CHW'(RST_CH);
         sdat_reg      <= 1'b0;
         oe_reg        <= 1'b0;
         done_reg      <= 1'b0;
         abort_reg     <= 1'b0;
         frame_cnt_reg <= '0;
      end else begin
         state_reg     <= state_next;
         shift_reg     <= shift_next;
         cnt_reg       <= cnt_next;
         addr_reg      <= addr_next;
         cur_ch_reg    <= cur_ch_next;
         next_ch_reg   <= next_ch_next;
         sdat_reg      <= sdat_next;
         oe_reg        <= oe_next;
         done_reg      <= done_next;
         abort_reg     <= abort_next;
         frame_cnt_reg <= frame_cnt_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      shift_next     = shift_reg;
      cnt_next       = cnt_reg;
      addr_next      = addr_reg;
      cur_ch_next    = cur_ch_reg;
      next_ch_next   = next_ch_reg;
      sdat_next      = sdat_reg;
      oe_next        = oe_reg;
      done_next      = 1'b0;
      abort_next     = 1'b0;
      frame_cnt_next = frame_cnt_reg;

      case (state_reg)
         IDLE: begin
            oe_next   = 1'b0;
            sdat_next = 1'b0;
            // A coincident SCLK fall is absorbed by the load (no shift).
            if (cs_fall) begin
               state_next  = SHIFT;
               shift_next  = load_word;
               cur_ch_next = next_ch_reg;
               cnt_next    = '0;
               oe_next     = 1'b1;
               sdat_next   = load_word[FRAME_BITS-1];
            end
         end

         SHIFT: begin
            // CS_N rise has priority over any SCLK edge in the same cycle.
            if (cs_rise) begin
               state_next = IDLE;
               abort_next = (cnt_reg != '0);
               oe_next    = 1'b0;
               sdat_next  = 1'b0;
            end else if (sclk_fall) begin
               // With no rise yet in this frame the MSB is already in place:
               // this fall is the frame's leading edge, so present without shifting.
               if (cnt_reg == '0) begin
                  sdat_next = shift_reg[FRAME_BITS-1];
               end else begin
                  shift_next = {shift_reg[FRAME_BITS-2:0], 1'b0};
                  sdat_next  = shift_reg[FRAME_BITS-2];
               end
            end else if (sclk_rise) begin
               cnt_next = cnt_inc;
               for (int j = 0; j < ADDR_BITS; j++) begin
                  if (cnt_inc == CW'(ADDR_RISE_FIRST + j))
                     addr_next[ADDR_BITS-1-j] = saddr_lvl;
               end
               if (cnt_inc == LAST_RISE) begin
                  done_next      = 1'b1;
                  frame_cnt_next = frame_cnt_reg + 16'd1;
                  next_ch_next   = addr_ch;
                  cur_ch_next    = addr_ch;
                  shift_next     = reload_word;
                  cnt_next       = '0;
               end
            end
         end

         default: state_next = IDLE;
      endcase
   end

   assign ADC_SDAT    = sdat_reg;
   assign sdat_oe     = oe_reg;
   assign cur_ch      = cur_ch_reg;
   assign frame_done  = done_reg;
   assign frame_abort = abort_reg;
   assign frame_cnt   = frame_cnt_reg;

endmodule

// File: tb/tb_adc_serial_responder.sv
// Bench for adc_serial_responder: drives the controller side of the serial
// interface; expected frame words are queued when a frame starts and popped
// when the frame's 16 bits have been collected.
module tb_adc_serial_responder;

   logic        CLOCK_50 = 1'b0;
   logic        n_reset;
   logic        ADC_CS_N;
   logic        ADC_SCLK;
   logic        ADC_SADDR;
   logic        ADC_SDAT;
   logic        sdat_oe;
   logic [95:0] ch_data;
   logic [2:0]  cur_ch;
   logic        frame_done;
   logic        frame_abort;
   logic [15:0] frame_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   int done_seen  = 0;
   int abort_seen = 0;

   logic [15:0] exp_q[$];
   logic [2:0]  model_next;

   adc_serial_responder dut (
      .CLOCK_50(CLOCK_50), .n_reset(n_reset),
      .ADC_CS_N(ADC_CS_N), .ADC_SCLK(ADC_SCLK), .ADC_SADDR(ADC_SADDR),
      .ADC_SDAT(ADC_SDAT), .sdat_oe(sdat_oe), .ch_data(ch_data),
      .cur_ch(cur_ch), .frame_done(frame_done), .frame_abort(frame_abort),
      .frame_cnt(frame_cnt));

   always #10 CLOCK_50 = ~CLOCK_50;

   always @(posedge CLOCK_50) begin
      if (frame_done === 1'b1)  done_seen++;
      if (frame_abort === 1'b1) abort_seen++;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] ch_word(input logic [2:0] k);
      return {4'h0, ch_data[int'(k)*12 +: 12]};
   endfunction

   task automatic wait_clk(input int n);
      repeat (n) @(negedge CLOCK_50);
   endtask

   // Runs nrises SCLK periods starting with SCLK already low. Returns the
   // bit seen just before each rise. If tfall matches a fall, checks that
   // ADC_SDAT changes exactly three clocks after that pin edge.
   task automatic run_bits(input logic [2:0] addr, input int nrises,
                           input int tfall, input logic [15:0] expw,
                           output logic [15:0] got);
      got = '0;
      for (int r = 1; r <= nrises; r++) begin
         ADC_SADDR = (r >= 3 && r <= 5) ? addr[5-r] : 1'b0;
         wait_clk(8);
         got = {got[14:0], ADC_SDAT};
         ADC_SCLK = 1'b1;
         wait_clk(8);
         if (r < nrises) begin
            ADC_SCLK = 1'b0;
            if (r == tfall) begin
               wait_clk(2);
               n_checks++;
               if (ADC_SDAT !== got[0]) begin
                  n_fail++;
                  $display("FAIL sdat_latency_early: ADC_SDAT=%b at 2 clocks, required %b", ADC_SDAT, got[0]);
               end
               wait_clk(1);
               n_checks++;
               if (ADC_SDAT !== expw[15-r]) begin
                  n_fail++;
                  $display("FAIL sdat_latency_3: ADC_SDAT=%b at 3 clocks, required %b", ADC_SDAT, expw[15-r]);
               end
            end
         end
      end
   endtask

   // One complete frame; b2b continues directly from the previous frame.
   task automatic full_frame(input logic [2:0] addr, input bit b2b, input int tfall,
                             input string name);
      logic [15:0] got, expw;
      expw = ch_word(model_next);
      exp_q.push_back(expw);
      if (!b2b) begin
         @(negedge CLOCK_50);
         ADC_CS_N = 1'b0;
         ADC_SCLK = 1'b0;
      end else begin
         ADC_SCLK = 1'b0;
      end
      run_bits(addr, 16, tfall, expw, got);
      model_next = addr;
      expw = exp_q.pop_front();
      n_checks++;
      if (got !== expw) begin
         n_fail++;
         $display("FAIL %s_word: got %h required %h", name, got, expw);
      end
      $display("frame %s: addr_sent=%0d word=%h", name, addr, got);
   endtask

   task automatic end_frame();
      ADC_CS_N  = 1'b1;
      ADC_SADDR = 1'b0;
      wait_clk(10);
   endtask

   task automatic test_reset();
      bit bad = 0;
      wait_clk(3);
      n_checks++;
      if (ADC_SDAT !== 1'b0 || sdat_oe !== 1'b0 || frame_cnt !== 16'd0 || cur_ch !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_values: sdat=%b oe=%b cnt=%h ch=%0d required 0 0 0000 0",
                  ADC_SDAT, sdat_oe, frame_cnt, cur_ch);
      end
      n_reset = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if (i % 4 == 0) ADC_SCLK = ~ADC_SCLK;
         @(negedge CLOCK_50);
         if (ADC_SDAT !== 1'b0 || sdat_oe !== 1'b0 || frame_cnt !== 16'd0 || cur_ch !== 3'd0)
            bad = 1;
      end
      ADC_SCLK = 1'b1;
      wait_clk(6);
      n_checks++;
      if (bad || done_seen != 0 || abort_seen != 0) begin
         n_fail++;
         $display("FAIL idle_sclk: outputs moved=%0d done=%0d abort=%0d required 0 0 0",
                  bad, done_seen, abort_seen);
      end
      $display("reset/idle: done");
   endtask

   task automatic test_single_frame();
      int d0 = done_seen;
      full_frame(3'd0, 0, 0, "single");
      n_checks++;
      if (sdat_oe !== 1'b1) begin
         n_fail++;
         $display("FAIL single_oe: sdat_oe=%b required 1", sdat_oe);
      end
      end_frame();
      n_checks++;
      if (done_seen != d0 + 1 || frame_cnt !== 16'd1) begin
         n_fail++;
         $display("FAIL single_done: pulses=%0d cnt=%0d required 1 1", done_seen - d0, frame_cnt);
      end
   endtask

   task automatic test_back_to_back();
      full_frame(3'd5, 0, 0, "b2b_addr");
      n_checks++;
      if (cur_ch !== 3'd5) begin
         n_fail++;
         $display("FAIL b2b_cur_ch: cur_ch=%0d required 5", cur_ch);
      end
      full_frame(3'd0, 1, 0, "b2b_read");
      end_frame();
      n_checks++;
      if (frame_cnt !== 16'd3) begin
         n_fail++;
         $display("FAIL b2b_cnt: frame_cnt=%0d required 3", frame_cnt);
      end
   endtask

   task automatic test_abort();
      logic [15:0] got;
      int d0 = done_seen;
      int a0 = abort_seen;
      @(negedge CLOCK_50);
      ADC_CS_N = 1'b0;
      ADC_SCLK = 1'b0;
      run_bits(3'b011, 7, 0, 16'h0, got);
      end_frame();
      n_checks++;
      if (abort_seen != a0 + 1 || done_seen != d0 || frame_cnt !== 16'd3) begin
         n_fail++;
         $display("FAIL abort: aborts=%0d dones=%0d cnt=%0d required 1 0 3",
                  abort_seen - a0, done_seen - d0, frame_cnt);
      end
      $display("abort: after 7 rises, addr 011 sent");
      full_frame(3'd0, 0, 0, "after_abort");
      end_frame();
   endtask

   task automatic test_timing();
      full_frame(3'd0, 0, 4, "timing");
      wait_clk(8);
      @(negedge CLOCK_50);
      ADC_CS_N = 1'b1;
      wait_clk(2);
      n_checks++;
      if (sdat_oe !== 1'b1) begin
         n_fail++;
         $display("FAIL oe_latency_early: sdat_oe=%b at 2 clocks, required 1", sdat_oe);
      end
      wait_clk(1);
      n_checks++;
      if (sdat_oe !== 1'b0 || ADC_SDAT !== 1'b0) begin
         n_fail++;
         $display("FAIL oe_latency_3: oe=%b sdat=%b at 3 clocks, required 0 0", sdat_oe, ADC_SDAT);
      end
      wait_clk(8);
   endtask

   task automatic test_wrap_reset();
      logic [15:0] got;
      @(negedge CLOCK_50);
      force dut.frame_cnt_reg = 16'hFFFF;
      @(negedge CLOCK_50);
      release dut.frame_cnt_reg;
      wait_clk(2);
      full_frame(3'd2, 0, 0, "wrap");
      end_frame();
      n_checks++;
      if (frame_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL wrap: frame_cnt=%h required 0000", frame_cnt);
      end
      full_frame(3'd6, 0, 0, "pre_reset");
      end_frame();
      // Frame on channel 6, interrupted by reset at bit 9.
      @(negedge CLOCK_50);
      ADC_CS_N = 1'b0;
      ADC_SCLK = 1'b0;
      run_bits(3'd1, 9, 0, 16'h0, got);
      n_checks++;
      if (sdat_oe !== 1'b1 || cur_ch !== 3'd6 || frame_cnt !== 16'd1) begin
         n_fail++;
         $display("FAIL pre_reset_state: oe=%b ch=%0d cnt=%0d required 1 6 1", sdat_oe, cur_ch, frame_cnt);
      end
      #3 n_reset = 1'b0;
      #1;
      n_checks++;
      if (ADC_SDAT !== 1'b0 || sdat_oe !== 1'b0 || cur_ch !== 3'd0 || frame_cnt !== 16'd0 ||
          frame_done !== 1'b0 || frame_abort !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: sdat=%b oe=%b ch=%0d cnt=%0d done=%b abort=%b required all 0",
                  ADC_SDAT, sdat_oe, cur_ch, frame_cnt, frame_done, frame_abort);
      end
      model_next = 3'd0;
      ADC_CS_N  = 1'b1;
      ADC_SCLK  = 1'b1;
      ADC_SADDR = 1'b0;
      wait_clk(4);
      n_reset = 1'b1;
      wait_clk(6);
      full_frame(3'd0, 0, 0, "post_reset");
      n_checks++;
      if (cur_ch !== 3'd0) begin
         n_fail++;
         $display("FAIL post_reset_ch: cur_ch=%0d required 0", cur_ch);
      end
      end_frame();
   endtask

   initial begin
      n_reset    = 1'b0;
      ADC_CS_N   = 1'b1;
      ADC_SCLK   = 1'b1;
      ADC_SADDR  = 1'b0;
      model_next = 3'd0;
      ch_data = {12'h7F1, 12'h6E6, 12'h123, 12'h4D4, 12'h3C3, 12'h2B7, 12'h111, 12'hA5C};

      test_reset();
      test_single_frame();
      test_back_to_back();
      test_abort();
      test_timing();
      test_wrap_reset();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
